// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared RV32F encodings for the FPU issue path: major opcodes,
//                OP-FP funct5 values, rounding-mode encodings, the issue FSM
//                state type and the writeback error codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Major opcodes
    localparam logic [6:0] c_OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] c_OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] c_OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] c_OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] c_OPC_FNMADD = 7'b1001111;

    // OP-FP funct5 (instr[31:27])
    localparam logic [4:0] c_F5_FADD     = 5'b00000;
    localparam logic [4:0] c_F5_FSUB     = 5'b00001;
    localparam logic [4:0] c_F5_FMUL     = 5'b00010;
    localparam logic [4:0] c_F5_FDIV     = 5'b00011;
    localparam logic [4:0] c_F5_FSGNJ    = 5'b00100;
    localparam logic [4:0] c_F5_FMINMAX  = 5'b00101;
    localparam logic [4:0] c_F5_FSQRT    = 5'b01011;
    localparam logic [4:0] c_F5_FCMP     = 5'b10100;
    localparam logic [4:0] c_F5_FCVT_W_S = 5'b11000;
    localparam logic [4:0] c_F5_FCVT_S_W = 5'b11010;
    localparam logic [4:0] c_F5_FMV_X_W  = 5'b11100;  // shared with FCLASS
    localparam logic [4:0] c_F5_FMV_W_X  = 5'b11110;

    // Rounding modes
    localparam logic [2:0] c_RM_RNE = 3'b000;
    localparam logic [2:0] c_RM_RTZ = 3'b001;
    localparam logic [2:0] c_RM_RDN = 3'b010;
    localparam logic [2:0] c_RM_RUP = 3'b011;
    localparam logic [2:0] c_RM_RMM = 3'b100;
    localparam logic [2:0] c_RM_DYN = 3'b111;

    // Writeback error codes
    localparam logic [1:0] c_ERR_OK      = 2'b00;
    localparam logic [1:0] c_ERR_RM      = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } fsmState_t;

endpackage
`default_nettype wire

// File: rtl/fpu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_op_decode
//  Description : Combinational RV32F classifier. Reports whether an op takes
//                a rounding mode and whether its result targets the integer
//                register file.
//  Ports       : i_instr   - 32-bit instruction word
//                o_usesRm  - op uses a rounding mode (funct3 is rm)
//                o_toInt   - result is written to an x-register
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_op_decode
    import fpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_usesRm,
    output logic        o_toInt
);

    logic [6:0] w_opcode;
    logic [4:0] w_funct5;

    assign w_opcode = i_instr[6:0];
    assign w_funct5 = i_instr[31:27];

    always_comb begin
        o_usesRm = 1'b0;
        o_toInt  = 1'b0;
        case (w_opcode)
            c_OPC_FMADD, c_OPC_FMSUB, c_OPC_FNMSUB, c_OPC_FNMADD: begin
                o_usesRm = 1'b1;
            end
            c_OPC_OP_FP: begin
                case (w_funct5)
                    c_F5_FADD, c_F5_FSUB, c_F5_FMUL, c_F5_FDIV,
                    c_F5_FSQRT, c_F5_FCVT_S_W: begin
                        o_usesRm = 1'b1;
                    end
                    c_F5_FCVT_W_S: begin
                        o_usesRm = 1'b1;
                        o_toInt  = 1'b1;
                    end
                    c_F5_FCMP, c_F5_FMV_X_W: begin
                        o_toInt  = 1'b1;
                    end
                    default: begin
                        o_usesRm = 1'b0;
                        o_toInt  = 1'b0;
                    end
                endcase
            end
            default: begin
                o_usesRm = 1'b0;
                o_toInt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_ctrl
//  Description : Core-side initiator for the FPU execute interface. Accepts
//                one RV32F op at a time, resolves its rounding mode, holds the
//                FPU request while busy (with a timeout) and presents the
//                result for writeback.
//  Ports       : clk_i/reset_i/flush_i           - clock, sync reset, flush
//                reqValid_i/reqReady_o/reqInstr_i/reqRs1..3_i/frm_i
//                                                - request side
//                fpuEnable_o/fpuInstr_o/fpuRs1..3_o/fpuRm_o/fpuBusy_i/fpuOut_i
//                                                - FPU side
//                wbValid_o/wbReady_i/wbToInt_o/wbRd_o/wbData_o/wbErr_o
//                                                - writeback side
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic [31:0] reqInstr_i,
    input  logic [31:0] reqRs1_i,
    input  logic [31:0] reqRs2_i,
    input  logic [31:0] reqRs3_i,
    input  logic [2:0]  frm_i,
    output logic        fpuEnable_o,
    output logic [31:0] fpuInstr_o,
    output logic [31:0] fpuRs1_o,
    output logic [31:0] fpuRs2_o,
    output logic [31:0] fpuRs3_o,
    output logic [2:0]  fpuRm_o,
    input  logic        fpuBusy_i,
    input  logic [31:0] fpuOut_i,
    output logic        wbValid_o,
    input  logic        wbReady_i,
    output logic        wbToInt_o,
    output logic [4:0]  wbRd_o,
    output logic [31:0] wbData_o,
    output logic [1:0]  wbErr_o
);

    // Counter value seen on the last allowed busy cycle
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fsmState_t         r_state;
    fsmState_t         w_nextState;

    logic [31:0]       r_instr;
    logic [31:0]       r_rs1;
    logic [31:0]       r_rs2;
    logic [31:0]       r_rs3;
    logic [2:0]        r_rm;
    logic [4:0]        r_rd;
    logic              r_toInt;
    logic [31:0]       r_data;
    logic [1:0]        r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_usesRm;
    logic              w_toInt;
    logic [2:0]        w_funct3;
    logic [2:0]        w_rm;
    logic              w_rmIllegal;
    logic              w_accept;
    logic              w_timeout;
    logic              w_issueActive;

    fpu_op_decode u_decode (
        .i_instr  (reqInstr_i),
        .o_usesRm (w_usesRm),
        .o_toInt  (w_toInt)
    );

    // Rounding mode: dynamic selects fcsr.frm; only rm-using ops are checked
    assign w_funct3    = reqInstr_i[14:12];
    assign w_rm        = (w_usesRm && (w_funct3 == c_RM_DYN)) ? frm_i : w_funct3;
    assign w_rmIllegal = w_usesRm && (w_rm > c_RM_RMM);

    // Flush blocks a same-cycle accept
    assign w_accept      = (r_state == ST_IDLE) && !flush_i && reqValid_i;
    assign w_timeout     = fpuBusy_i && (r_cnt == c_CNT_LAST);
    assign w_issueActive = (r_state == ST_ISSUE) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        reqReady_o  = 1'b0;
        fpuEnable_o = 1'b0;
        wbValid_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                reqReady_o = !flush_i;
                if (w_accept) begin
                    w_nextState = w_rmIllegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpuEnable_o = 1'b1;
                if (!fpuBusy_i || w_timeout) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                wbValid_o = 1'b1;
                if (wbReady_i) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (flush_i) begin
            w_nextState = ST_IDLE;
        end
    end

    // Request/result holding registers and the busy-cycle counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_instr <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rs3   <= '0;
            r_rm    <= '0;
            r_rd    <= '0;
            r_toInt <= 1'b0;
            r_data  <= '0;
            r_err   <= c_ERR_OK;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_instr <= reqInstr_i;
            r_rs1   <= reqRs1_i;
            r_rs2   <= reqRs2_i;
            r_rs3   <= reqRs3_i;
            r_rm    <= w_rm;
            r_rd    <= reqInstr_i[11:7];
            r_toInt <= w_toInt;
            r_data  <= '0;
            r_err   <= w_rmIllegal ? c_ERR_RM : c_ERR_OK;
            r_cnt   <= '0;
        end else if (w_issueActive) begin
            if (!fpuBusy_i) begin
                r_data <= fpuOut_i;
                r_err  <= c_ERR_OK;
            end else if (w_timeout) begin
                r_data <= '0;
                r_err  <= c_ERR_TIMEOUT;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign fpuInstr_o = r_instr;
    assign fpuRs1_o   = r_rs1;
    assign fpuRs2_o   = r_rs2;
    assign fpuRs3_o   = r_rs3;
    assign fpuRm_o    = r_rm;
    assign wbToInt_o  = r_toInt;
    assign wbRd_o     = r_rd;
    assign wbData_o   = r_data;
    assign wbErr_o    = r_err;

endmodule
`default_nettype wire
